// File: rtl/amm_master_tester.sv
// Avalon-MM self-test master: writes an address-derived pattern over a block of
// words, reads it back and reports mismatches, first failing address and watchdog aborts.
module amm_master_tester #(
  parameter int DDR_DATA_WIDTH = 64,
  parameter int DDR_ADDR_WIDTH = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT        = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DDR_ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]      num_words,
  input  logic [DDR_DATA_WIDTH-1:0] seed,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      err_cnt,
  output logic [DDR_ADDR_WIDTH-1:0] first_err_addr,
  output logic                      timeout,
  input  logic                      local_init_done,
  input  logic                      amm_wait,
  output logic [DDR_ADDR_WIDTH-1:0] amm_addr,
  output logic                      amm_ren,
  output logic                      amm_wen,
  output logic [DDR_DATA_WIDTH-1:0] amm_wdata,
  output logic [5:0]                amm_burstcount,
  input  logic                      amm_rvalid,
  input  logic [DDR_DATA_WIDTH-1:0] amm_rdata,
  output logic [2:0]                dbg_state
);

  localparam int DW   = DDR_DATA_WIDTH;
  localparam int AW   = DDR_ADDR_WIDTH;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_RWAIT = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Handshake: a request (amm_ren or amm_wen) is accepted in any cycle where it is
  // high and amm_wait is low; while amm_wait is high the request, address and data hold.

  state_t          state_q;
  logic            busy_q, done_q, tmo_q, ren_q, wen_q;
  logic [AW-1:0]   base_q, addr_q, ferr_q;
  logic [DW-1:0]   seed_q, wdata_q;
  logic [CNT_WIDTH-1:0] cnt_q, idx_q, err_q;
  logic [WD_W-1:0] wd_q;

  logic [AW-1:0]        addr_d;
  logic [CNT_WIDTH-1:0] idx_d, err_d;
  logic [DW-1:0]        wdata_d;
  logic                 last, mismatch, cmp_fire;

  // {~a, a} is zero-extended or truncated to the data width, then masked by the seed.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic [DW-1:0] s);
    logic [DW+2*AW-1:0] ext;
    ext = {{DW{1'b0}}, ~a, a};
    return ext[DW-1:0] ^ s;
  endfunction

  assign addr_d   = addr_q + 1'b1;
  assign idx_d    = idx_q + 1'b1;
  assign last     = (idx_d == cnt_q);
  assign wdata_d  = pattern(addr_d, seed_q);
  assign err_d    = (&err_q) ? err_q : err_q + 1'b1;
  assign mismatch = (amm_rdata != pattern(addr_q, seed_q));
  assign cmp_fire = ((state_q == S_READ) && !amm_wait && amm_rvalid) ||
                    ((state_q == S_RWAIT) && amm_rvalid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      base_q  <= '0;
      addr_q  <= '0;
      ferr_q  <= '0;
      seed_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      wd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_INIT;
            busy_q  <= 1'b1;
            err_q   <= '0;
            ferr_q  <= '0;
            tmo_q   <= 1'b0;
            base_q  <= base_addr;
            cnt_q   <= num_words;
            seed_q  <= seed;
            idx_q   <= '0;
            wd_q    <= '0;
          end
        end
        S_INIT: begin
          if (cnt_q == '0) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (local_init_done) begin
            state_q <= S_WRITE;
            wen_q   <= 1'b1;
            addr_q  <= base_q;
            wdata_q <= pattern(base_q, seed_q);
          end
        end
        S_WRITE: begin
          if (!amm_wait) begin
            wd_q  <= '0;
            idx_q <= idx_d;
            if (last) begin
              state_q <= S_READ;
              wen_q   <= 1'b0;
              ren_q   <= 1'b1;
              addr_q  <= base_q;
              idx_q   <= '0;
            end else begin
              addr_q  <= addr_d;
              wdata_q <= wdata_d;
            end
          end else if (wd_q == WD_MAX) begin
            state_q <= S_FIN;
            wen_q   <= 1'b0;
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_READ, S_RWAIT: begin
          if (cmp_fire) begin
            wd_q  <= '0;
            idx_q <= idx_d;
            if (mismatch) begin
              err_q <= err_d;
              if (err_q == '0) ferr_q <= addr_q;
            end
            if (last) begin
              state_q <= S_FIN;
              ren_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_READ;
              ren_q   <= 1'b1;
              addr_q  <= addr_d;
            end
          end else if ((state_q == S_READ) && !amm_wait) begin
            // Accepted without data: park until rvalid, only one read in flight.
            state_q <= S_RWAIT;
            ren_q   <= 1'b0;
            wd_q    <= '0;
          end else if (wd_q == WD_MAX) begin
            state_q <= S_FIN;
            ren_q   <= 1'b0;
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;
  assign timeout        = tmo_q;
  assign amm_addr       = addr_q;
  assign amm_ren        = ren_q;
  assign amm_wen        = wen_q;
  assign amm_wdata      = wdata_q;
  assign amm_burstcount = 6'd1;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_amm_master_tester.sv
// Directed bench for amm_master_tester: a behavioural Avalon-MM slave with memory,
// protocol checks on every cycle, and a linear sequence of self-test scenarios.
module tb_amm_master_tester;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_words;
  logic [63:0] seed;
  logic        busy, done, timeout;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr;
  logic        local_init_done;
  logic        amm_wait;
  logic [31:0] amm_addr;
  logic        amm_ren, amm_wen;
  logic [63:0] amm_wdata;
  logic [5:0]  amm_burstcount;
  logic        amm_rvalid;
  logic [63:0] amm_rdata;
  logic [2:0]  dbg_state;

  amm_master_tester #(
    .DDR_DATA_WIDTH(64), .DDR_ADDR_WIDTH(32), .CNT_WIDTH(16), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .busy(busy), .done(done),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .timeout(timeout),
    .local_init_done(local_init_done), .amm_wait(amm_wait), .amm_addr(amm_addr),
    .amm_ren(amm_ren), .amm_wen(amm_wen), .amm_wdata(amm_wdata),
    .amm_burstcount(amm_burstcount), .amm_rvalid(amm_rvalid), .amm_rdata(amm_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // slave configuration: wait_mode 0 = never, 1 = random bounded, 2 = stuck high
  int          wait_mode = 0;
  int          rv_mode   = 0;
  bit          corrupt_en = 1'b0;
  logic [63:0] mem [logic [31:0]];
  logic [31:0] wr_a[$];
  logic [63:0] wr_d[$];
  logic [31:0] rd_a[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] tb_pat(input logic [31:0] a, input logic [63:0] s);
    return {~a, a} ^ s;
  endfunction

  function automatic logic [63:0] slave_read(input logic [31:0] a);
    logic [63:0] d;
    d = mem.exists(a) ? mem[a] : 64'h0;
    if (corrupt_en && (a == 32'h102 || a == 32'h105)) d = d ^ 64'h1;
    return d;
  endfunction

  // slave model and per-cycle protocol checks, evaluated 1 time unit after each edge
  initial begin
    int          rv_cnt, wait_run, lat;
    logic [63:0] rv_data;
    logic        p_wait, p_ren, p_wen;
    logic [31:0] p_addr;
    logic [63:0] p_wdata;
    rv_cnt = 0; wait_run = 0; rv_data = '0;
    p_wait = 0; p_ren = 0; p_wen = 0; p_addr = '0; p_wdata = '0;
    amm_wait = 1'b0; amm_rvalid = 1'b0; amm_rdata = '0;
    forever begin
      @(posedge clk); #1;
      amm_rvalid = 1'b0;
      if (!rst) begin
        rv_cnt = 0; wait_run = 0; amm_wait = 1'b0;
        p_wait = 0; p_ren = 0; p_wen = 0;
      end else begin
        if (amm_ren || amm_wen) chk("ren_wen_exclusive", {63'd0, amm_ren & amm_wen}, 64'd0);
        if (p_wait && (p_ren || p_wen) && wait_mode != 2) begin
          chk("hold_ctrl", {62'd0, amm_ren, amm_wen}, {62'd0, p_ren, p_wen});
          chk("hold_addr", {32'd0, amm_addr}, {32'd0, p_addr});
          if (p_wen) chk("hold_wdata", amm_wdata, p_wdata);
        end
        if (!local_init_done && busy) chk("no_req_before_init", {62'd0, amm_ren, amm_wen}, 64'd0);
        if (rv_cnt > 0) begin
          rv_cnt--;
          if (rv_cnt == 0) begin amm_rvalid = 1'b1; amm_rdata = rv_data; end
        end
        case (wait_mode)
          1: amm_wait = (wait_run >= 6) ? 1'b0 : 1'($urandom_range(0, 1));
          2: amm_wait = 1'b1;
          default: amm_wait = 1'b0;
        endcase
        wait_run = amm_wait ? wait_run + 1 : 0;
        if (amm_wen && !amm_wait) begin
          mem[amm_addr] = amm_wdata;
          wr_a.push_back(amm_addr);
          wr_d.push_back(amm_wdata);
        end
        if (amm_ren && !amm_wait) begin
          rd_a.push_back(amm_addr);
          lat = (rv_mode != 0) ? int'($urandom_range(0, 3)) : 0;
          if (lat == 0) begin amm_rvalid = 1'b1; amm_rdata = slave_read(amm_addr); end
          else begin rv_cnt = lat; rv_data = slave_read(amm_addr); end
        end
        p_wait = amm_wait; p_ren = amm_ren; p_wen = amm_wen;
        p_addr = amm_addr; p_wdata = amm_wdata;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_test(input logic [31:0] a, input logic [15:0] n, input logic [63:0] s);
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    base_addr = a; num_words = n; seed = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    int k;
    k = 0;
    while (!done && k < budget) begin tick(); k++; end
    cyc = k;
    chk({tag, "_done_seen"}, {63'd0, done}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: observed no finish, required finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cyc;
    bit seen;
    rst = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; seed = '0;
    local_init_done = 1'b1;
    repeat (3) tick();

    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err_cnt", {48'd0, err_cnt}, 64'd0);
    chk("rst_first_err", {32'd0, first_err_addr}, 64'd0);
    chk("rst_timeout", {63'd0, timeout}, 64'd0);
    chk("rst_req", {62'd0, amm_ren, amm_wen}, 64'd0);
    chk("rst_addr", {32'd0, amm_addr}, 64'd0);
    chk("rst_wdata", amm_wdata, 64'd0);
    chk("rst_burstcount", {58'd0, amm_burstcount}, 64'd1);
    rst = 1'b1;
    tick();

    // basic run: zero-wait slave, same-cycle read data
    start_test(32'h100, 16'd4, 64'd0);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    wait_done("t1", 200, cyc);
    chk("t1_latency", 64'(cyc), 64'd9);
    chk("t1_err_cnt", {48'd0, err_cnt}, 64'd0);
    chk("t1_timeout", {63'd0, timeout}, 64'd0);
    chk("t1_busy_at_done", {63'd0, busy}, 64'd0);
    chk("t1_nwrites", 64'(wr_a.size()), 64'd4);
    chk("t1_wd0", wr_d[0], 64'hFFFFFEFF_00000100);
    chk("t1_wd1", wr_d[1], 64'hFFFFFEFE_00000101);
    chk("t1_wd2", wr_d[2], 64'hFFFFFEFD_00000102);
    chk("t1_wd3", wr_d[3], 64'hFFFFFEFC_00000103);
    chk("t1_wa3", {32'd0, wr_a[3]}, 64'h103);
    chk("t1_nreads", 64'(rd_a.size()), 64'd4);
    chk("t1_ra0", {32'd0, rd_a[0]}, 64'h100);
    chk("t1_ra3", {32'd0, rd_a[3]}, 64'h103);
    tick();
    chk("t1_done_one_cycle", {63'd0, done}, 64'd0);

    // randomized waitrequest and read latency
    wait_mode = 1; rv_mode = 1;
    start_test(32'h2000, 16'd64, 64'hA5A5A5A5A5A5A5A5);
    wait_done("t2", 4000, cyc);
    chk("t2_err_cnt", {48'd0, err_cnt}, 64'd0);
    chk("t2_timeout", {63'd0, timeout}, 64'd0);
    chk("t2_nwrites", 64'(wr_a.size()), 64'd64);
    chk("t2_nreads", 64'(rd_a.size()), 64'd64);
    for (int i = 0; i < 64 && i < wr_a.size(); i++) begin
      chk("t2_waddr", {32'd0, wr_a[i]}, {32'd0, 32'h2000 + 32'(i)});
      chk("t2_wdata", wr_d[i], tb_pat(32'h2000 + 32'(i), 64'hA5A5A5A5A5A5A5A5));
    end
    wait_mode = 0;
    tick();

    // corrupted read data at 0x102 and 0x105
    corrupt_en = 1'b1;
    start_test(32'h100, 16'd8, 64'h1234);
    wait_done("t3", 400, cyc);
    chk("t3_err_cnt", {48'd0, err_cnt}, 64'd2);
    chk("t3_first_err", {32'd0, first_err_addr}, 64'h102);
    corrupt_en = 1'b0; rv_mode = 0;
    tick();

    // address wrap at the top of the space
    start_test(32'hFFFFFFFE, 16'd4, 64'd0);
    wait_done("t4", 200, cyc);
    chk("t4_err_cnt", {48'd0, err_cnt}, 64'd0);
    chk("t4_first_err_cleared", {32'd0, first_err_addr}, 64'd0);
    chk("t4_wa0", {32'd0, wr_a[0]}, 64'hFFFFFFFE);
    chk("t4_wd0", wr_d[0], 64'h00000001_FFFFFFFE);
    chk("t4_wa2", {32'd0, wr_a[2]}, 64'h0);
    chk("t4_wa3", {32'd0, wr_a[3]}, 64'h1);
    tick();

    // memory not ready for 50 cycles
    local_init_done = 1'b0;
    start_test(32'h300, 16'd4, 64'd0);
    for (int i = 0; i < 50; i++) begin
      chk("t5_busy_while_init", {63'd0, busy}, 64'd1);
      chk("t5_no_req", {62'd0, amm_ren, amm_wen}, 64'd0);
      tick();
    end
    local_init_done = 1'b1;
    wait_done("t5", 200, cyc);
    chk("t5_err_cnt", {48'd0, err_cnt}, 64'd0);
    chk("t5_nwrites", 64'(wr_a.size()), 64'd4);
    tick();

    // waitrequest stuck high: abort 16 cycles after the first request
    wait_mode = 2;
    start_test(32'h40, 16'd4, 64'd0);
    tick();
    chk("t6_wen_up", {63'd0, amm_wen}, 64'd1);
    repeat (15) tick();
    chk("t6_wen_held", {63'd0, amm_wen}, 64'd1);
    chk("t6_not_done_yet", {63'd0, done}, 64'd0);
    tick();
    chk("t6_done", {63'd0, done}, 64'd1);
    chk("t6_req_dropped", {62'd0, amm_ren, amm_wen}, 64'd0);
    chk("t6_timeout", {63'd0, timeout}, 64'd1);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("t6_timeout_sticky", {63'd0, timeout}, 64'd1);
    wait_mode = 0;
    tick();

    // zero-length test
    start_test(32'h500, 16'd0, 64'd0);
    chk("t7_busy", {63'd0, busy}, 64'd1);
    chk("t7_timeout_cleared", {63'd0, timeout}, 64'd0);
    wait_done("t7", 20, cyc);
    chk("t7_latency", 64'(cyc), 64'd1);
    chk("t7_no_req", {62'd0, amm_ren, amm_wen}, 64'd0);
    chk("t7_nwrites", 64'(wr_a.size()), 64'd0);
    tick();

    // asynchronous reset in the middle of the read phase
    rv_mode = 1;
    start_test(32'h700, 16'd8, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (amm_ren) seen = 1'b1;
      else tick();
    end
    chk("t8_read_reached", {63'd0, seen}, 64'd1);
    #3 rst = 1'b0;
    #1;
    chk("t8_busy", {63'd0, busy}, 64'd0);
    chk("t8_req", {62'd0, amm_ren, amm_wen}, 64'd0);
    chk("t8_addr", {32'd0, amm_addr}, 64'd0);
    chk("t8_state", {61'd0, dbg_state}, 64'd0);
    chk("t8_burstcount", {58'd0, amm_burstcount}, 64'd1);
    tick();
    chk("t8_no_done", {63'd0, done}, 64'd0);
    rst = 1'b1;
    tick();
    start_test(32'h700, 16'd8, 64'h0F0F);
    wait_done("t8_rerun", 400, cyc);
    chk("t8_err_cnt", {48'd0, err_cnt}, 64'd0);
    chk("t8_nreads", 64'(rd_a.size()), 64'd8);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/amm_master_tester.md
Name: amm_master_tester

Overview:
- Avalon-MM style master that drives the DDR memory port from the initiator side.
- On a start pulse it writes a deterministic address-derived pattern to a block of words, then reads the block back and compares.
- Reports completion, error count, first failing address and watchdog timeout.
- Connects directly to the DDR slave interface (simulation model or controller); used as a bring-up/self-test engine.

Parameters:
- DDR_DATA_WIDTH, 64, data bus width.
- DDR_ADDR_WIDTH, 32, word address width.
- CNT_WIDTH, 16, width of word count and error count.
- TIMEOUT, 1024, max cycles waiting on one transaction (amm_wait high or rvalid pending) before abort.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; asynchronous, active-low (asserted when 0).
- start, input, 1, one-cycle pulse; begins a test when idle.
- base_addr, input, DDR_ADDR_WIDTH, first word address; sampled at start.
- num_words, input, CNT_WIDTH, words to test; sampled at start.
- seed, input, DDR_DATA_WIDTH, pattern XOR mask; sampled at start.
- busy, output, 1, test in progress.
- done, output, 1, one-cycle pulse at completion or abort.
- err_cnt, output, CNT_WIDTH, number of mismatching reads, saturating.
- first_err_addr, output, DDR_ADDR_WIDTH, address of first mismatch.
- timeout, output, 1, sticky; the last test aborted on watchdog.
- local_init_done, input, 1, memory ready.
- amm_wait, input, 1, slave waitrequest.
- amm_addr, output, DDR_ADDR_WIDTH, word address.
- amm_ren, output, 1, read request.
- amm_wen, output, 1, write request.
- amm_wdata, output, DDR_DATA_WIDTH, write data.
- amm_burstcount, output, 6, constant 1.
- amm_rvalid, input, 1, read data valid.
- amm_rdata, input, DDR_DATA_WIDTH, read data.

Behaviour:
- Reset values: all outputs 0 except amm_burstcount = 1. State is IDLE.
- Pattern: P(a) = ({~a, a} zero-extended or truncated to DDR_DATA_WIDTH) XOR seed_reg.
- States:
  - IDLE -> INIT on start while idle. start is ignored while busy.
  - INIT waits for local_init_done = 1. Entering INIT: busy = 1; err_cnt, first_err_addr and timeout cleared; base, count and seed latched. If num_words = 0, go to FIN.
  - WRITE: drives amm_wen = 1, amm_addr = base + i, amm_wdata = P(base + i).
    - Accept when amm_wen = 1 and amm_wait = 0 in the same cycle.
    - Address, data and wen are held stable while amm_wait = 1.
    - On accept i increments. After the last accept go to READ with i = 0.
  - READ: drives amm_ren = 1, amm_addr = base + i, held while amm_wait = 1.
    - On accept, if amm_rvalid = 1 in that cycle, compare immediately. Otherwise go to RWAIT with amm_ren = 0.
  - RWAIT: waits for amm_rvalid, then compares.
  - After each compare: i increments. Go to READ, or to FIN after the last word.
  - Only one read is outstanding at a time. amm_ren and amm_wen are never asserted together.
  - Requests are issued back-to-back: a new request may be asserted the cycle after accept.
  - FIN: done = 1 for one cycle, busy = 0, return to IDLE.
- Compare on mismatch (amm_rdata != P(addr)):
  - err_cnt increments, saturating at all ones.
  - first_err_addr is written only when err_cnt was 0.
- amm_rvalid outside READ/RWAIT is ignored.
- Watchdog:
  - Counter runs during WRITE, READ and RWAIT; it resets on each accept or compare.
  - Reaching TIMEOUT: drop amm_ren/amm_wen, set timeout = 1, go to FIN.
  - The watchdog is not active in INIT.
- Address arithmetic wraps modulo 2^DDR_ADDR_WIDTH.
- Reset mid-operation: immediate return to IDLE, requests deasserted, no done pulse.

Test Plan:
- Slave with amm_wait = 0 on accept cycle, base = 0x100, num_words = 4, seed = 0 -> 4 writes then 4 reads, addresses 0x100..0x103. Write data for 0x100 = 0xFFFFFEFF_00000100. done after last compare, err_cnt = 0, timeout = 0.
- Randomized amm_wait (about 50%), num_words = 64, seed = 0xA5A5A5A5A5A5A5A5 -> addr/wdata/ren/wen stable during every wait cycle, no simultaneous ren/wen, err_cnt = 0.
- Slave corrupts the read data of word 0x102 and 0x105, base = 0x100, num_words = 8 -> err_cnt = 2, first_err_addr = 0x102.
- local_init_done held 0 for 50 cycles after start -> no request before it rises. busy = 1 throughout. Then normal completion.
- amm_wait stuck 1 with TIMEOUT = 16 -> abort 16 cycles after the request is first asserted: timeout = 1, done pulse, requests dropped. num_words = 0 -> done two cycles after start, no requests.
- rst driven to 0 mid-read -> outputs 0 asynchronously. After release, a new start runs a clean test with err_cnt = 0.
